dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester access controller in front of the word-organised data memory (32-bit words, byte-lane write enables, combinational read, write on rising clock edge).
- Port 0 is the CPU load/store unit; port 1 is the loader/debug DMA.
- Arbitrates between the ports, generates byte-lane enables from size and address, and checks alignment and range.
- Returns sign- or zero-extended read data through a registered 2-stage pipeline.

Parameters:
- MEM_AW, 17, byte-address width backed by memory; any address with addr[31:MEM_AW] non-zero is out of range.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- p0_req, p1_req  in  1 each  request valid; held until granted
- p0_wr, p1_wr  in  1 each  1 = store, 0 = load
- p0_size, p1_size  in  2 each  00 = byte, 01 = half, 10 = word, 11 = illegal
- p0_uns, p1_uns  in  1 each  load zero-extend when 1
- p0_addr, p1_addr  in  32 each  byte address
- p0_wdata, p1_wdata  in  32 each  store data, right-justified
- p0_gnt, p1_gnt  out  1 each  request accepted this cycle (combinational)
- p0_rvalid, p1_rvalid  out  1 each  response valid
- p0_rdata, p1_rdata  out  32 each  extended load data
- p0_err, p1_err  out  1 each  response carries error
- mem_we  out  4  byte-lane write enables
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  store data, right-justified (memory packs consecutive low bytes into the enabled lanes)
- mem_rdata  in  32  combinational read word

Behaviour:
- Reset values: gnt = 0, rvalid = 0, err = 0, rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, last-grant pointer = 1 (port 0 wins first).
- Arbitration (cycle T):
  - At most one gnt per cycle; a request with no competitor is granted immediately.
  - Both requesting, FIXED_PRIO = 0: grant the port not granted last; pointer updates only on a grant.
  - Both requesting, FIXED_PRIO = 1: port 0 wins.
  - gnt is forced to 0 while rst_n = 0.
- Stage A (cycle T+1): the granted request is registered as valid, owner, wr, size, uns, addr[1:0], err.
  - mem_addr = registered addr; mem_wdata = registered wdata.
  - mem_we = lane mask if wr and no error, else 0000. Writes commit on the edge ending T+1.
- Lane mask:
  - byte: 0001 << addr[1:0]
  - half: 0011 << (2 × addr[1])
  - word: 1111
- Error conditions (the access is accepted, never stalls, never writes):
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 00
  - size = 11
  - out-of-range address
- Stage B (cycle T+2): owner's rvalid = 1 for exactly one cycle, for both loads and stores.
  - Load rdata = mem_rdata sampled at end of T+1, shifted right by 8 × addr[1:0], then sign- or zero-extended from 8 or 16 bits; word loads pass through.
  - Stores and errors return rdata = 0; err = 1 on error.
- Throughput and latency: one access per cycle; load-to-response latency 2 cycles. A load granted the cycle after a store to the same word returns the new data.
- Non-owner port: rvalid = 0 and its rdata holds its last value.
- Reset mid-operation: both stages are invalidated asynchronously and mem_we drops to 0 immediately. An in-flight store is dropped and no response is issued. After rst_n deasserts, arbitration restarts with port 0 preferred.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_B / SZ_H / SZ_W / SZ_BAD
  - port index constants
  - a function computing lane mask and alignment error
- One combinational sub-module, dmem_lane_align: load-data shift and sign/zero extension.
- The arbiter, pipeline registers and memory-port drive stay in dmem_arbiter.

Test Plan:
- p0 word store addr 0x100 data 0xDEADBEEF -> p0_gnt in T, mem_we = 1111 in T+1, p0_rvalid with err = 0 in T+2. A later p0 word load of 0x100 returns 0xDEADBEEF.
- p1 byte load addr 0x103 (word 0xDEADBEEF), uns = 0 -> rdata 0xFFFFFFDE. Same access with uns = 1 -> 0x000000DE. Half store 0x1234 at 0x102 -> mem_we = 1100.
- Both ports request continuously, FIXED_PRIO = 0 -> grants p0, p1, p0, p1, one per cycle, each response 2 cycles after its grant. With FIXED_PRIO = 1, p1 is granted only once p0 drops req.
- p0 word store addr 0x102 -> gnt, mem_we stays 0000, rvalid and err = 1 at T+2, memory unchanged. Same result for size = 11 and for addr 0x00020000.
- Store 0xA5 byte at 0x10 in T, p1 load word 0x10 granted T+1 -> p1 rdata[7:0] = 0xA5.
- rst_n pulsed low during stage A of a store -> mem_we drops to 0 asynchronously, no rvalid, memory unchanged; the first post-reset contention grants p0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NLANE = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic            wr;
    size_e           size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [NLANE-1:0] we;
    logic             misalign;
  } lane_t;

  // Byte-lane mask plus alignment/size legality for one access.
  function automatic lane_t lane_decode(input size_e size, input logic [1:0] addr_lo);
    lane_t l;
    l.we       = '0;
    l.misalign = 1'b0;
    case (size)
      SZ_B: l.we = NLANE'(4'b0001 << addr_lo);
      SZ_H: begin
        l.we       = NLANE'(4'b0011 << {addr_lo[1], 1'b0});
        l.misalign = addr_lo[0];
      end
      SZ_W: begin
        l.we       = NLANE'(4'b1111);
        l.misalign = (addr_lo != 2'b00);
      end
      default: l.misalign = 1'b1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Load-data alignment: shifts the addressed bytes down and sign/zero extends them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  size_e           i_size,
  input  logic            i_uns,
  input  logic [1:0]      i_addr_lo,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shift;
  logic            w_sign_b;
  logic            w_sign_h;

  assign w_shift  = i_word >> {i_addr_lo, 3'b000};
  assign w_sign_b = ~i_uns & w_shift[7];
  assign w_sign_h = ~i_uns & w_shift[15];

  // Word loads are always aligned here, so the shifted word is the raw word.
  always_comb begin
    o_data = w_shift;
    case (i_size)
      SZ_B:    o_data = {{(XLEN-8){w_sign_b}}, w_shift[7:0]};
      SZ_H:    o_data = {{(XLEN-16){w_sign_h}}, w_shift[15:0]};
      default: o_data = w_shift;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory access controller: arbitration, lane enables,
// alignment/range checking and a two-stage registered response path.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_AW     = 17,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req,
  input  logic            p0_wr,
  input  logic [1:0]      p0_size,
  input  logic            p0_uns,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  input  logic            p1_req,
  input  logic            p1_wr,
  input  logic [1:0]      p1_size,
  input  logic            p1_uns,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p0_gnt,
  output logic            p1_gnt,
  output logic            p0_rvalid,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  output logic [XLEN-1:0] p1_rdata,
  output logic            p0_err,
  output logic            p1_err,
  output logic [NLANE-1:0] mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  req_t  w_p0;
  req_t  w_p1;
  req_t  w_req;
  lane_t w_lane;
  logic  w_gnt0;
  logic  w_gnt1;
  logic  w_any_gnt;
  logic  w_oor;
  logic  w_err;

  // 1 = port 1 was granted most recently, so port 0 is preferred next.
  logic r_last;

  logic       r_a_valid;
  logic       r_a_owner;
  logic       r_a_wr;
  size_e      r_a_size;
  logic       r_a_uns;
  logic [1:0] r_a_lo;
  logic       r_a_err;

  logic [NLANE-1:0] r_mem_we;
  logic [XLEN-1:0]  r_mem_addr;
  logic [XLEN-1:0]  r_mem_wdata;

  logic            r_p0_rvalid;
  logic            r_p1_rvalid;
  logic [XLEN-1:0] r_p0_rdata;
  logic [XLEN-1:0] r_p1_rdata;
  logic            r_p0_err;
  logic            r_p1_err;

  logic [XLEN-1:0] w_ld_data;
  logic [XLEN-1:0] w_resp;
  logic            w_a_p0;
  logic            w_a_p1;

  always_comb begin
    w_p0.wr    = p0_wr;
    w_p0.size  = size_e'(p0_size);
    w_p0.uns   = p0_uns;
    w_p0.addr  = p0_addr;
    w_p0.wdata = p0_wdata;
    w_p1.wr    = p1_wr;
    w_p1.size  = size_e'(p1_size);
    w_p1.uns   = p1_uns;
    w_p1.addr  = p1_addr;
    w_p1.wdata = p1_wdata;
  end

  // Single-grant arbitration; grants are suppressed while reset is asserted.
  assign w_gnt0    = rst_n & p0_req & (~p1_req | FIXED_PRIO | r_last);
  assign w_gnt1    = rst_n & p1_req & ~w_gnt0;
  assign w_any_gnt = w_gnt0 | w_gnt1;
  assign p0_gnt    = w_gnt0;
  assign p1_gnt    = w_gnt1;

  assign w_req  = w_gnt1 ? w_p1 : w_p0;
  assign w_lane = lane_decode(w_req.size, w_req.addr[1:0]);
  assign w_oor  = (w_req.addr >> MEM_AW) != '0;
  assign w_err  = w_lane.misalign | w_oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT1;
    end else if (w_any_gnt) begin
      r_last <= w_gnt1;
    end
  end

  // Stage A: capture the granted access and drive the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid   <= 1'b0;
      r_a_owner   <= PORT0;
      r_a_wr      <= 1'b0;
      r_a_size    <= SZ_B;
      r_a_uns     <= 1'b0;
      r_a_lo      <= 2'b00;
      r_a_err     <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_a_valid <= w_any_gnt;
      r_mem_we  <= (w_any_gnt && w_req.wr && !w_err) ? w_lane.we : '0;
      if (w_any_gnt) begin
        r_a_owner   <= w_gnt1;
        r_a_wr      <= w_req.wr;
        r_a_size    <= w_req.size;
        r_a_uns     <= w_req.uns;
        r_a_lo      <= w_req.addr[1:0];
        r_a_err     <= w_err;
        r_mem_addr  <= w_req.addr;
        r_mem_wdata <= w_req.wdata;
      end
    end
  end

  dmem_lane_align u_align (
    .i_word    (mem_rdata),
    .i_size    (r_a_size),
    .i_uns     (r_a_uns),
    .i_addr_lo (r_a_lo),
    .o_data    (w_ld_data)
  );

  assign w_resp = (r_a_wr | r_a_err) ? '0 : w_ld_data;
  assign w_a_p0 = r_a_valid & (r_a_owner == PORT0);
  assign w_a_p1 = r_a_valid & (r_a_owner == PORT1);

  // Stage B: one-cycle response to the owner; the other port keeps its rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_err    <= 1'b0;
      r_p1_err    <= 1'b0;
    end else begin
      r_p0_rvalid <= w_a_p0;
      r_p1_rvalid <= w_a_p1;
      r_p0_err    <= w_a_p0 & r_a_err;
      r_p1_err    <= w_a_p1 & r_a_err;
      if (w_a_p0) r_p0_rdata <= w_resp;
      if (w_a_p1) r_p1_rdata <= w_resp;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign p0_rvalid = r_p0_rvalid;
  assign p1_rvalid = r_p1_rvalid;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign p0_err    = r_p0_err;
  assign p1_err    = r_p1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed cases plus random traffic against a
// transaction-level model of memory contents and response timing.
module tb_dmem_arbiter;

  localparam int unsigned MEM_AW = 17;

  logic        clk;
  logic        rst_n;
  logic        mem_clr;
  logic        p0_req, p0_wr, p0_uns, p1_req, p1_wr, p1_uns;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid, fp_p0_err, fp_p1_err;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_we;

  logic [31:0] mem [0:255];
  int          n_checks;
  int          n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_AW(MEM_AW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Fixed-priority instance sees the same requests; only its grants are examined.
  dmem_arbiter #(.MEM_AW(MEM_AW), .FIXED_PRIO(1'b1)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(fp_p0_gnt), .p1_gnt(fp_p1_gnt), .p0_rvalid(fp_p0_rvalid), .p1_rvalid(fp_p1_rvalid),
    .p0_rdata(fp_p0_rdata), .p1_rdata(fp_p1_rdata), .p0_err(fp_p0_err), .p1_err(fp_p1_err),
    .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_rdata(32'h0)
  );

  // Memory: combinational read, enabled lanes take consecutive low bytes of wdata.
  assign mem_rdata = mem[mem_addr[9:2]];

  function automatic int lanes_below(input logic [3:0] we, input int lane);
    int c;
    c = 0;
    for (int j = 0; j < lane; j++) if (we[j]) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*lanes_below(mem_we, i) +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        port;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
  } txn_t;

  txn_t        sa;
  logic        sa_v;
  logic        sb_v, sb_port, sb_err;
  logic [31:0] sb_rdata;
  logic        m_last;
  logic [31:0] last_rd [2];
  logic [31:0] ref_mem [256];

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (off % 2) != 0) return 1'b1;
    if (size == 2'd2 && off != 0) return 1'b1;
    return (addr / (32'd1 << MEM_AW)) != 0;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [1:0] size, input logic [31:0] addr);
    int off, nb;
    logic [3:0] m;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4) / nb * nb;
    m   = 4'h0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nb) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] word);
    logic [31:0] s;
    s = word >> (8 * (addr % 4));
    if (size == 2'd0) begin
      s = s & 32'hFF;
      if (!uns && s >= 32'h80) s = s | 32'hFFFF_FF00;
      return s;
    end
    if (size == 2'd1) begin
      s = s & 32'hFFFF;
      if (!uns && s >= 32'h8000) s = s | 32'hFFFF_0000;
      return s;
    end
    return word;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [3:0] m, input logic [31:0] wd);
    int k;
    logic [31:0] w;
    k = 0;
    w = ref_mem[addr[9:2]];
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        w[8*i +: 8] = wd[8*k +: 8];
        k++;
      end
    ref_mem[addr[9:2]] = w;
  endtask

  // Monitor: grants in the cycle, memory write one cycle later, response two later.
  initial begin : monitor
    logic e0, e1, ev;
    logic [3:0] ew;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sa_v = 1'b0; sb_v = 1'b0; m_last = 1'b1;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        check_eq("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        check_eq("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        check_eq("rst_mem_we", {28'd0, mem_we}, 32'd0);
      end else begin
        e0 = p0_req && (!p1_req || m_last);
        e1 = p1_req && !e0;
        check_eq("gnt", {30'd0, p1_gnt, p0_gnt}, {30'd0, e1, e0});

        ev = sb_v && !sb_port;
        if (ev) last_rd[0] = sb_rdata;
        check_eq("p0_rvalid", {31'd0, p0_rvalid}, {31'd0, ev});
        check_eq("p0_err", {31'd0, p0_err}, {31'd0, ev && sb_err});
        check_eq("p0_rdata", p0_rdata, last_rd[0]);
        ev = sb_v && sb_port;
        if (ev) last_rd[1] = sb_rdata;
        check_eq("p1_rvalid", {31'd0, p1_rvalid}, {31'd0, ev});
        check_eq("p1_err", {31'd0, p1_err}, {31'd0, ev && sb_err});
        check_eq("p1_rdata", p1_rdata, last_rd[1]);

        ew = (sa_v && sa.wr && !sa.err) ? ref_mask(sa.size, sa.addr) : 4'h0;
        check_eq("mem_we", {28'd0, mem_we}, {28'd0, ew});
        if (ew != 4'h0) begin
          check_eq("mem_addr", mem_addr, sa.addr);
          check_eq("mem_wdata", mem_wdata, sa.wdata);
        end
        sb_v = sa_v; sb_port = sa.port; sb_err = sa.err;
        sb_rdata = (sa.wr || sa.err) ? 32'h0 : ref_load(sa.size, sa.uns, sa.addr, ref_mem[sa.addr[9:2]]);
        if (ew != 4'h0) ref_store(sa.addr, ew, sa.wdata);

        sa_v = e0 || e1;
        if (e1) sa = '{port: 1'b1, wr: p1_wr, size: p1_size, uns: p1_uns, addr: p1_addr, wdata: p1_wdata, err: 1'b0};
        else    sa = '{port: 1'b0, wr: p0_wr, size: p0_size, uns: p0_uns, addr: p0_addr, wdata: p0_wdata, err: 1'b0};
        sa.err = ref_err(sa.size, sa.addr);
        if (sa_v) m_last = e1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic port, input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = 1'b1; p1_wr = wr; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_wr = wr; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic issue(input logic port, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    set_req(port, wr, size, uns, addr, wdata);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = port ? p1_gnt : p0_gnt;
    end
    check_eq("gnt_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
  endtask

  task automatic wait_resp(input logic port, output logic [31:0] rd, output logic er);
    logic seen;
    seen = 1'b0; rd = 32'h0; er = 1'b0;
    for (int n = 0; n < 6 && !seen; n++) begin
      @(negedge clk);
      seen = port ? p1_rvalid : p0_rvalid;
      rd   = port ? p1_rdata : p0_rdata;
      er   = port ? p1_err : p0_err;
    end
    check_eq("resp_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input logic port);
    int r;
    logic [1:0] sz;
    logic [31:0] a;
    r  = int'($urandom_range(0, 15));
    sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
    a  = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'd1) a = a & ~32'd1;
      if (sz == 2'd2) a = a & ~32'd3;
    end
    if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hFFFE_0000) | 32'h0002_0000;
    set_req(port, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : stim
    logic [31:0] rd, old;
    logic er, g0, g1, prev0;
    int nbad;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; mem_clr = 1'b1;
    p0_req = 0; p0_wr = 0; p0_size = 0; p0_uns = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_wr = 0; p1_size = 0; p1_uns = 0; p1_addr = 0; p1_wdata = 0;
    sa = '0; sa_v = 0; sb_v = 0; sb_port = 0; sb_err = 0; sb_rdata = 0; m_last = 1;
    last_rd[0] = 0; last_rd[1] = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Reset state, with a request present to prove gnt is held low.
    p0_req = 1'b1; p0_addr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    check_eq("rst_p0_rdata", p0_rdata, 32'd0);
    check_eq("rst_p1_err", {31'd0, p1_err}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    p0_req = 1'b0; rst_n = 1'b1; mem_clr = 1'b0;

    // Word store then load back.
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    check_eq("st_w_mem_we", {28'd0, mem_we}, 32'hF);
    wait_resp(1'b0, rd, er);
    check_eq("st_w_err", {31'd0, er}, 32'd0);
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    wait_resp(1'b0, rd, er);
    check_eq("ld_w_data", rd, 32'hDEAD_BEEF);

    // Byte loads with sign and zero extension; half store lane mask.
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    wait_resp(1'b1, rd, er);
    check_eq("ld_b_signed", rd, 32'hFFFF_FFDE);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    wait_resp(1'b1, rd, er);
    check_eq("ld_b_unsigned", rd, 32'h0000_00DE);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234);
    check_eq("st_h_mem_we", {28'd0, mem_we}, 32'hC);
    wait_resp(1'b0, rd, er);

    // Continuous contention: round-robin alternates, fixed priority keeps p0.
    set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    prev0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("rr_one_gnt", {31'd0, p0_gnt} + {31'd0, p1_gnt}, 32'd1);
      if (i > 0) check_eq("rr_alternate", {31'd0, p0_gnt}, {31'd0, ~prev0});
      prev0 = p0_gnt;
      check_eq("fp_p0_wins", {30'd0, fp_p1_gnt, fp_p0_gnt}, 32'd1);
      @(posedge clk); #1;
    end
    p0_req = 1'b0;
    @(negedge clk);
    check_eq("fp_p1_after_drop", {31'd0, fp_p1_gnt}, 32'd1);
    check_eq("fp_no_write", {28'd0, fp_mem_we}, 32'd0);
    @(posedge clk); #1;
    p1_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Error accesses: misaligned word, illegal size, out of range.
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFF_FFFF);
    check_eq("err_mis_we", {28'd0, mem_we}, 32'd0);
    wait_resp(1'b0, rd, er);
    check_eq("err_mis_flag", {31'd0, er}, 32'd1);
    check_eq("err_mis_rdata", rd, 32'd0);
    issue(1'b0, 1'b1, 2'd3, 1'b0, 32'h100, 32'hFFFF_FFFF);
    check_eq("err_sz_we", {28'd0, mem_we}, 32'd0);
    wait_resp(1'b0, rd, er);
    check_eq("err_sz_flag", {31'd0, er}, 32'd1);
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0002_0000, 32'hFFFF_FFFF);
    check_eq("err_oor_we", {28'd0, mem_we}, 32'd0);
    wait_resp(1'b0, rd, er);
    check_eq("err_oor_flag", {31'd0, er}, 32'd1);
    check_eq("err_mem_intact", mem[64], 32'h1234_BEEF);

    // Load granted the cycle after a store to the same word sees the new byte.
    set_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_00A5);
    @(negedge clk);
    check_eq("fwd_st_gnt", {31'd0, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check_eq("fwd_ld_gnt", {31'd0, p1_gnt}, 32'd1);
    @(posedge clk); #1;
    p1_req = 1'b0;
    wait_resp(1'b1, rd, er);
    check_eq("fwd_byte", rd & 32'hFF, 32'hA5);

    // Reset during stage A of a store: write dropped, no response.
    old = mem[8];
    set_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h55AA_55AA);
    @(negedge clk);
    check_eq("rst_st_gnt", {31'd0, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_we", {28'd0, mem_we}, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("rst_mem_kept", mem[8], old);
    set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    check_eq("post_rst_prio", {30'd0, p1_gnt, p0_gnt}, 32'd1);
    @(posedge clk); #1;
    p0_req = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    p1_req = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Random traffic on both ports.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      g0 = p0_gnt; g1 = p1_gnt;
      @(posedge clk); #1;
      if (!p0_req || g0) begin
        if ($urandom_range(0, 9) < 6) rand_req(1'b0); else p0_req = 1'b0;
      end
      if (!p1_req || g1) begin
        if ($urandom_range(0, 9) < 6) rand_req(1'b1); else p1_req = 1'b0;
      end
    end
    @(negedge clk);
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (4) @(posedge clk); #1;

    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check_eq("mem_final_words_bad", 32'(nbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
